// File: rtl/vga_pkg.sv
// Shared constants for the VGA timing blocks: mode encodings, per-mode
// sync/max geometry, default field widths and the mode-config FSM states.
package vga_pkg;

    localparam int PULSE_WIDTH_DEF   = 8;
    localparam int REZ_MAX_WIDTH_DEF = 12;

    localparam logic [1:0] MODE_640  = 2'd0;
    localparam logic [1:0] MODE_800  = 2'd1;
    localparam logic [1:0] MODE_SIM  = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    localparam int H_SYNC_640 = 96;
    localparam int H_MAX_640  = 800;
    localparam int V_SYNC_640 = 2;
    localparam int V_MAX_640  = 525;

    localparam int H_SYNC_800 = 128;
    localparam int H_MAX_800  = 1056;
    localparam int V_SYNC_800 = 4;
    localparam int V_MAX_800  = 628;

    // Tiny geometry so simulations reach frame boundaries quickly.
    localparam int H_SYNC_SIM = 1;
    localparam int H_MAX_SIM  = 8;
    localparam int V_SYNC_SIM = 1;
    localparam int V_MAX_SIM  = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_PENDING = 2'd1;
    localparam state_t ST_HOLD    = 2'd2;

endpackage

// File: rtl/vga_mode_rom.sv
// Combinational mode lookup: mode number to sync/max geometry plus a
// valid flag (the reserved mode is the only invalid one).
module vga_mode_rom
    import vga_pkg::*;
#(
    parameter int PULSE_WIDTH   = PULSE_WIDTH_DEF,
    parameter int REZ_MAX_WIDTH = REZ_MAX_WIDTH_DEF
) (
    input  logic [1:0]               mode_sel,
    output logic [PULSE_WIDTH-1:0]   h_sync,
    output logic [REZ_MAX_WIDTH-1:0] h_max,
    output logic [PULSE_WIDTH-1:0]   v_sync,
    output logic [REZ_MAX_WIDTH-1:0] v_max,
    output logic                     valid
);

    always_comb begin
        h_sync = PULSE_WIDTH'(H_SYNC_640);
        h_max  = REZ_MAX_WIDTH'(H_MAX_640);
        v_sync = PULSE_WIDTH'(V_SYNC_640);
        v_max  = REZ_MAX_WIDTH'(V_MAX_640);
        valid  = 1'b1;
        case (mode_sel)
            MODE_800: begin
                h_sync = PULSE_WIDTH'(H_SYNC_800);
                h_max  = REZ_MAX_WIDTH'(H_MAX_800);
                v_sync = PULSE_WIDTH'(V_SYNC_800);
                v_max  = REZ_MAX_WIDTH'(V_MAX_800);
            end
            MODE_SIM: begin
                h_sync = PULSE_WIDTH'(H_SYNC_SIM);
                h_max  = REZ_MAX_WIDTH'(H_MAX_SIM);
                v_sync = PULSE_WIDTH'(V_SYNC_SIM);
                v_max  = REZ_MAX_WIDTH'(V_MAX_SIM);
            end
            MODE_RSVD: valid = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: rtl/vga_mode_config.sv
// Video mode holder for the VGA counters: defers mode switches to a frame
// boundary, holds the counters for HOLD_CYCLES, then acknowledges.
module vga_mode_config
    import vga_pkg::*;
#(
    parameter int PULSE_WIDTH   = PULSE_WIDTH_DEF,
    parameter int REZ_MAX_WIDTH = REZ_MAX_WIDTH_DEF,
    parameter int HOLD_CYCLES   = 2     // 1..15
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [1:0]               Mode_sel,
    input  logic                     Mode_req,
    input  logic                     Frame_end,
    output logic [PULSE_WIDTH-1:0]   H_sync_pulse,
    output logic [REZ_MAX_WIDTH-1:0] H_count_max,
    output logic [PULSE_WIDTH-1:0]   V_sync_pulse,
    output logic [REZ_MAX_WIDTH-1:0] V_count_max,
    output logic                     Counter_hold,
    output logic                     Busy,
    output logic                     Mode_ack,
    output logic                     Mode_err,
    output logic [1:0]               Cur_mode
);

    localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES - 1);

    state_t                   state;
    logic [1:0]               pend_mode;
    logic [3:0]               hold_cnt;
    logic [1:0]               rom_sel;
    logic [PULSE_WIDTH-1:0]   rom_h_sync;
    logic [REZ_MAX_WIDTH-1:0] rom_h_max;
    logic [PULSE_WIDTH-1:0]   rom_v_sync;
    logic [REZ_MAX_WIDTH-1:0] rom_v_max;
    logic                     rom_valid;

    // In IDLE the ROM validates the incoming request; otherwise it serves
    // the latched pending mode for the frame-boundary load.
    assign rom_sel = (state == ST_IDLE) ? Mode_sel : pend_mode;

    vga_mode_rom #(
        .PULSE_WIDTH  (PULSE_WIDTH),
        .REZ_MAX_WIDTH(REZ_MAX_WIDTH)
    ) u_rom (
        .mode_sel(rom_sel),
        .h_sync  (rom_h_sync),
        .h_max   (rom_h_max),
        .v_sync  (rom_v_sync),
        .v_max   (rom_v_max),
        .valid   (rom_valid)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= ST_IDLE;
            pend_mode    <= MODE_640;
            hold_cnt     <= '0;
            H_sync_pulse <= PULSE_WIDTH'(H_SYNC_640);
            H_count_max  <= REZ_MAX_WIDTH'(H_MAX_640);
            V_sync_pulse <= PULSE_WIDTH'(V_SYNC_640);
            V_count_max  <= REZ_MAX_WIDTH'(V_MAX_640);
            Cur_mode     <= MODE_640;
            Counter_hold <= 1'b0;
            Busy         <= 1'b0;
            Mode_ack     <= 1'b0;
            Mode_err     <= 1'b0;
        end else begin
            Mode_ack <= 1'b0;
            Mode_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Frame_end here is deliberately not consumed, even if
                    // it coincides with the request.
                    if (Mode_req) begin
                        if (!rom_valid) begin
                            Mode_err <= 1'b1;
                        end else if (Mode_sel == Cur_mode) begin
                            Mode_ack <= 1'b1;
                        end else begin
                            pend_mode <= Mode_sel;
                            Busy      <= 1'b1;
                            state     <= ST_PENDING;
                        end
                    end
                end
                ST_PENDING: begin
                    if (Frame_end) begin
                        H_sync_pulse <= rom_h_sync;
                        H_count_max  <= rom_h_max;
                        V_sync_pulse <= rom_v_sync;
                        V_count_max  <= rom_v_max;
                        Cur_mode     <= pend_mode;
                        Counter_hold <= 1'b1;
                        hold_cnt     <= HOLD_INIT;
                        state        <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == 4'd0) begin
                        Counter_hold <= 1'b0;
                        Mode_ack     <= 1'b1;
                        Busy         <= 1'b0;
                        state        <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_mode_config.sv
// Bench for vga_mode_config: event-timeline model checked every cycle, plus
// directed literal checks for the documented scenarios and a random soak.
module tb_vga_mode_config;

    localparam int HC = 2;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [1:0]  Mode_sel = 2'd0;
    logic        Mode_req = 1'b0;
    logic        Frame_end = 1'b0;
    logic [7:0]  H_sync_pulse;
    logic [11:0] H_count_max;
    logic [7:0]  V_sync_pulse;
    logic [11:0] V_count_max;
    logic        Counter_hold;
    logic        Busy;
    logic        Mode_ack;
    logic        Mode_err;
    logic [1:0]  Cur_mode;

    vga_mode_config #(
        .PULSE_WIDTH  (8),
        .REZ_MAX_WIDTH(12),
        .HOLD_CYCLES  (HC)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Mode_sel    (Mode_sel),
        .Mode_req    (Mode_req),
        .Frame_end   (Frame_end),
        .H_sync_pulse(H_sync_pulse),
        .H_count_max (H_count_max),
        .V_sync_pulse(V_sync_pulse),
        .V_count_max (V_count_max),
        .Counter_hold(Counter_hold),
        .Busy        (Busy),
        .Mode_ack    (Mode_ack),
        .Mode_err    (Mode_err),
        .Cur_mode    (Cur_mode)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    int hs_tab [4] = '{96, 128, 1, 0};
    int hm_tab [4] = '{800, 1056, 8, 0};
    int vs_tab [4] = '{2, 4, 1, 0};
    int vm_tab [4] = '{525, 628, 4, 0};

    // Model: edge numbers at which things happen rather than FSM state.
    bit model_on = 1'b0;
    int n        = 0;
    int e_mode   = 0;
    bit pend_v   = 1'b0;
    int pend_m   = 0;
    int fe_at    = -1;
    int ack_at   = -1;
    int err_at   = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_busy();
        return pend_v || (fe_at >= 0 && n < fe_at + HC);
    endfunction

    task automatic model_cycle();
        bit b;
        if (model_on) begin
            chk("h_sync",  32'(H_sync_pulse), 32'(hs_tab[e_mode]));
            chk("h_max",   32'(H_count_max),  32'(hm_tab[e_mode]));
            chk("v_sync",  32'(V_sync_pulse), 32'(vs_tab[e_mode]));
            chk("v_max",   32'(V_count_max),  32'(vm_tab[e_mode]));
            chk("cur_mode", 32'(Cur_mode),    32'(e_mode));
            chk("hold", 32'(Counter_hold), 32'(fe_at >= 0 && n >= fe_at && n < fe_at + HC));
            chk("busy", 32'(Busy),     32'(model_busy()));
            chk("ack",  32'(Mode_ack), 32'(n == ack_at));
            chk("err",  32'(Mode_err), 32'(n == err_at));
        end
        b = model_busy();
        if (Rst) begin
            model_on = 1'b1;
            e_mode = 0; pend_v = 1'b0; fe_at = -1; ack_at = -1; err_at = -1;
        end else if (!b && Mode_req) begin
            if (Mode_sel == 2'd3) err_at = n + 1;
            else if (int'(Mode_sel) == e_mode) ack_at = n + 1;
            else begin
                pend_v = 1'b1;
                pend_m = int'(Mode_sel);
            end
        end else if (pend_v && Frame_end) begin
            e_mode = pend_m;
            pend_v = 1'b0;
            fe_at  = n + 1;
            ack_at = n + 1 + HC;
        end
        n++;
    endtask

    task automatic step();
        @(negedge Clk);
        model_cycle();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        // Reset defaults
        Rst = 1'b1;
        step(); step();
        chk("rst_h_sync", 32'(H_sync_pulse), 32'd96);
        chk("rst_h_max",  32'(H_count_max),  32'd800);
        chk("rst_v_sync", 32'(V_sync_pulse), 32'd2);
        chk("rst_v_max",  32'(V_count_max),  32'd525);
        chk("rst_busy",   32'(Busy),         32'd0);
        Rst = 1'b0;
        step();

        // Same-mode request and reserved-mode error
        Mode_req = 1'b1; Mode_sel = 2'd0;
        step();
        Mode_req = 1'b0;
        chk("same_ack",  32'(Mode_ack), 32'd1);
        chk("same_busy", 32'(Busy),     32'd0);
        Mode_req = 1'b1; Mode_sel = 2'd3;
        step();
        Mode_req = 1'b0;
        chk("err_pulse", 32'(Mode_err),    32'd1);
        chk("err_h_max", 32'(H_count_max), 32'd800);

        // Normal switch to mode 1
        Mode_req = 1'b1; Mode_sel = 2'd1;
        step();
        Mode_req = 1'b0;
        chk("sw_busy", 32'(Busy), 32'd1);
        repeat (5) step();
        chk("sw_h_max_wait", 32'(H_count_max), 32'd800);
        Frame_end = 1'b1;
        step();
        Frame_end = 1'b0;
        chk("sw_h_sync", 32'(H_sync_pulse), 32'd128);
        chk("sw_h_max",  32'(H_count_max),  32'd1056);
        chk("sw_v_sync", 32'(V_sync_pulse), 32'd4);
        chk("sw_v_max",  32'(V_count_max),  32'd628);
        chk("sw_hold1",  32'(Counter_hold), 32'd1);
        step();
        chk("sw_hold2", 32'(Counter_hold), 32'd1);
        chk("sw_noack", 32'(Mode_ack),     32'd0);
        step();
        chk("sw_hold_off", 32'(Counter_hold), 32'd0);
        chk("sw_ack",      32'(Mode_ack),     32'd1);
        chk("sw_busy_off", 32'(Busy),         32'd0);
        step();
        chk("sw_ack_once", 32'(Mode_ack), 32'd0);

        // Request coincident with Frame_end waits for the next frame
        Mode_req = 1'b1; Mode_sel = 2'd2; Frame_end = 1'b1;
        step();
        Mode_req = 1'b0; Frame_end = 1'b0;
        chk("sim_pend_busy", 32'(Busy),         32'd1);
        chk("sim_pend_hmax", 32'(H_count_max),  32'd1056);
        chk("sim_pend_hold", 32'(Counter_hold), 32'd0);
        repeat (3) step();
        Frame_end = 1'b1;
        step();
        Frame_end = 1'b0;
        chk("sim_h_max", 32'(H_count_max), 32'd8);
        chk("sim_v_max", 32'(V_count_max), 32'd4);
        repeat (3) step();

        // Second request while busy is ignored
        Mode_req = 1'b1; Mode_sel = 2'd0;
        step();
        Mode_sel = 2'd1;
        step();
        Mode_req = 1'b0;
        chk("ign_busy", 32'(Busy), 32'd1);
        Frame_end = 1'b1;
        step();
        Frame_end = 1'b0;
        chk("ign_cur", 32'(Cur_mode), 32'd0);
        step(); step();
        chk("ign_ack", 32'(Mode_ack), 32'd1);
        step();
        chk("ign_single_ack", 32'(Mode_ack), 32'd0);
        chk("ign_idle",       32'(Busy),     32'd0);

        // Reset during PENDING
        Mode_req = 1'b1; Mode_sel = 2'd2;
        step();
        Mode_req = 1'b0;
        chk("rp_busy", 32'(Busy), 32'd1);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        chk("rp_busy_clr", 32'(Busy),        32'd0);
        chk("rp_h_max",    32'(H_count_max), 32'd800);
        Frame_end = 1'b1;
        step();
        Frame_end = 1'b0;
        chk("rp_fe_h_max", 32'(H_count_max),  32'd800);
        chk("rp_fe_hold",  32'(Counter_hold), 32'd0);
        step();
        chk("rp_noack", 32'(Mode_ack), 32'd0);

        // Reset during HOLD
        Mode_req = 1'b1; Mode_sel = 2'd1;
        step();
        Mode_req = 1'b0;
        step();
        Frame_end = 1'b1;
        step();
        Frame_end = 1'b0;
        chk("rh_hold", 32'(Counter_hold), 32'd1);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        chk("rh_hold_clr", 32'(Counter_hold), 32'd0);
        chk("rh_h_max",    32'(H_count_max),  32'd800);
        chk("rh_cur",      32'(Cur_mode),     32'd0);
        step();
        chk("rh_noack1", 32'(Mode_ack), 32'd0);
        Frame_end = 1'b1;
        step();
        Frame_end = 1'b0;
        chk("rh_noack2", 32'(Mode_ack),    32'd0);
        chk("rh_fe_max", 32'(H_count_max), 32'd800);

        // Random soak against the model
        for (int i = 0; i < 3000; i++) begin
            Rst       = ($urandom_range(0, 299) == 0);
            Mode_req  = ($urandom_range(0, 7) == 0);
            Mode_sel  = 2'($urandom_range(0, 3));
            Frame_end = ($urandom_range(0, 15) == 0);
            step();
        end
        Rst = 1'b0; Mode_req = 1'b0; Frame_end = 1'b0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
